// File: rtl/rx_buf_ctrl.sv
// ---------------------------------------------------------------------------
// rx_buf_ctrl
//   Receive-side byte FIFO between the UART receiver (writer) and the CPU
//   (reader). Bytes land in a simple dual-port block RAM used as a circular
//   buffer and are returned in order with a fixed one-cycle read latency.
//
// Ports
//   clk       single clock, all logic on posedge
//   rst       synchronous reset, active-high
//   rx_valid  1-cycle strobe: rx_data holds a new byte
//   rx_data   received byte
//   rd_req    CPU read request, sampled every cycle
//   rd_valid  1-cycle pulse: rd_data holds the byte for an accepted request
//   rd_data   byte output, holds until the next rd_valid
//   empty     1 when count == 0 (registered)
//   full      1 when count == DEPTH (registered)
//   count     bytes currently stored (registered)
//   overflow  sticky: a byte arrived while full and was dropped
//   ovf_clr   clears overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module rx_buf_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  // Circular pointer increment; DEPTH need not be a power of two, so the
  // wrap is an explicit compare rather than natural roll-over.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    logic [ADDR_W-1:0] r;
    if (p == LAST_PTR) begin
      r = {ADDR_W{1'b0}};
    end else begin
      r = p + ADDR_W'(1);
    end
    return r;
  endfunction

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              rd_valid_r;
  logic [7:0]        rd_data_r;
  logic              overflow_r;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              wr_drop_s;

  // Accept decisions use the registered (pre-edge) flags only, so a write
  // arriving while full is dropped even if a read frees a slot this cycle.
  always_comb begin
    wr_acc_s  = rx_valid & ~full_r;
    rd_acc_s  = rd_req & ~empty_r;
    wr_drop_s = rx_valid & full_r;
  end

  // Next occupancy: +1 on write only, -1 on read only, unchanged otherwise.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + (ADDR_W + 1)'(1);
      2'b01:   count_nxt_s = count_r - (ADDR_W + 1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and the registered flags derived from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      count_r  <= {(ADDR_W + 1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_CNT);
      empty_r <= (count_nxt_s == {(ADDR_W + 1){1'b0}});
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem[wr_ptr_r] <= rx_data;
    end
  end

  // RAM read port with registered output; updated only on accepted reads so
  // rd_data holds between rd_valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= 8'h00;
    end else if (rd_acc_s) begin
      rd_data_r <= mem[rd_ptr_r];
    end
  end

  // Read-valid pulse, one cycle after each accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_acc_s;
    end
  end

  // Sticky overflow; a drop in the same cycle as ovf_clr keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (wr_drop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clr) begin
      overflow_r <= 1'b0;
    end
  end

  assign rd_valid = rd_valid_r;
  assign rd_data  = rd_data_r;
  assign empty    = empty_r;
  assign full     = full_r;
  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_rx_buf_ctrl.sv
// Bench for rx_buf_ctrl: two instances (DEPTH=4 and DEPTH=3) share one input
// stream; each is compared every cycle against a queue-based reference model.
module tb_rx_buf_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rd_req;
  logic       ovf_clr;

  logic       rd_valid4, empty4, full4, overflow4;
  logic [7:0] rd_data4;
  logic [2:0] count4;
  logic       rd_valid3, empty3, full3, overflow3;
  logic [7:0] rd_data3;
  logic [2:0] count3;

  int errors = 0;
  int checks = 0;

  // reference model state per instance (0: DEPTH=4, 1: DEPTH=3)
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         mdepth [2] = '{4, 3};
  logic       m_ovf  [2];
  logic       m_rv   [2];
  logic [7:0] m_rd   [2];

  always #5 clk = ~clk;

  rx_buf_ctrl #(.DEPTH(4), .ADDR_W(2)) dut4 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rd_req(rd_req), .rd_valid(rd_valid4), .rd_data(rd_data4),
    .empty(empty4), .full(full4), .count(count4),
    .overflow(overflow4), .ovf_clr(ovf_clr)
  );

  rx_buf_ctrl #(.DEPTH(3), .ADDR_W(2)) dut3 (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rd_req(rd_req), .rd_valid(rd_valid3), .rd_data(rd_data3),
    .empty(empty3), .full(full3), .count(count3),
    .overflow(overflow3), .ovf_clr(ovf_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the FIFO's behaviour, from pre-edge occupancy.
  task automatic model_edge(input int k);
    int         sz;
    logic [7:0] b;
    sz = (k == 0) ? q0.size() : q1.size();
    if (rst) begin
      if (k == 0) q0.delete(); else q1.delete();
      m_ovf[k] = 1'b0;
      m_rv[k]  = 1'b0;
      m_rd[k]  = 8'h00;
    end else begin
      if (rd_req && sz > 0) begin
        if (k == 0) b = q0.pop_front(); else b = q1.pop_front();
        m_rd[k] = b;
        m_rv[k] = 1'b1;
      end else begin
        m_rv[k] = 1'b0;
      end
      if (rx_valid && sz == mdepth[k]) begin
        m_ovf[k] = 1'b1;
      end else begin
        if (rx_valid) begin
          if (k == 0) q0.push_back(rx_data); else q1.push_back(rx_data);
        end
        if (ovf_clr) m_ovf[k] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    int s0, s1;
    s0 = q0.size();
    s1 = q1.size();
    chk("d4.rd_valid", {31'd0, rd_valid4}, {31'd0, m_rv[0]});
    chk("d4.rd_data",  {24'd0, rd_data4},  {24'd0, m_rd[0]});
    chk("d4.count",    {29'd0, count4},    s0);
    chk("d4.empty",    {31'd0, empty4},    {31'd0, (s0 == 0)});
    chk("d4.full",     {31'd0, full4},     {31'd0, (s0 == 4)});
    chk("d4.overflow", {31'd0, overflow4}, {31'd0, m_ovf[0]});
    chk("d3.rd_valid", {31'd0, rd_valid3}, {31'd0, m_rv[1]});
    chk("d3.rd_data",  {24'd0, rd_data3},  {24'd0, m_rd[1]});
    chk("d3.count",    {29'd0, count3},    s1);
    chk("d3.empty",    {31'd0, empty3},    {31'd0, (s1 == 0)});
    chk("d3.full",     {31'd0, full3},     {31'd0, (s1 == 3)});
    chk("d3.overflow", {31'd0, overflow3}, {31'd0, m_ovf[1]});
  endtask

  // Apply inputs for one cycle, advance the model across the edge, compare.
  task automatic step(input logic v, input logic [7:0] d, input logic r,
                      input logic c, input logic rs);
    rx_valid = v;
    rx_data  = d;
    rd_req   = r;
    ovf_clr  = c;
    rst      = rs;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rd_req = 1'b0; ovf_clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_ovf[k] = 1'b0; m_rv[k] = 1'b0; m_rd[k] = 8'h00;
    end

    // reset state
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // two bytes in, two bytes out
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // read while empty is ignored
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // fill past capacity, drain, clear overflow
    for (int i = 1; i <= 5; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)  step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // write-then-read rounds, pointers wrap
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    // simultaneous write and read at count 2
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // read from full with a same-cycle write (dropped), ovf_clr vs drop
    for (int i = 0; i < 4; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // reset during a back-to-back drain
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h52, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h53, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // randomized traffic, alternating write-heavy and read-heavy phases
    for (int i = 0; i < 400; i++) begin
      int wp;
      int rp;
      wp = ((i / 50) % 2 == 0) ? 70 : 30;
      rp = ((i / 50) % 2 == 0) ? 30 : 70;
      step(($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
           ($urandom_range(0, 199) < 1) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
